// File: rtl/mem_bus_master.sv
// CPU-side bus master: arbitrates fetch/data requests onto a single-port memory.
// Optional byte-lane stores (read-modify-write) are enabled with `define MEM_BUS_BYTE_LANE_EN.
module mem_bus_master #(
    parameter int MEM_AW    = 30,
    parameter bit ALIGN_CHK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ready,
    output logic [31:0]       i_instr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
`ifdef MEM_BUS_BYTE_LANE_EN
    input  logic [3:0]        d_be,
`endif
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

`ifdef MEM_BUS_BYTE_LANE_EN
    typedef enum logic [2:0] {IDLE, RD, WR, REJ, RMW_RD, RMW_WR} state_t;
`else
    typedef enum logic [1:0] {IDLE, RD, WR, REJ} state_t;
`endif

    state_t      state, state_n;
    logic        last_fetch;
    logic        cur_fetch;
    logic        grant;
    logic        sel_fetch;
    logic        sel_store;
    logic        misalign;
    logic [31:0] sel_addr;
`ifdef MEM_BUS_BYTE_LANE_EN
    logic [3:0]  lat_be;
    logic [31:0] merged;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        state_n   = state;
        grant     = 1'b0;
        sel_fetch = i_req && !(d_req && last_fetch);
        sel_addr  = sel_fetch ? i_addr : d_addr;
        sel_store = !sel_fetch && d_we;
        misalign  = ALIGN_CHK && (sel_addr[1:0] != 2'b00);
        case (state)
            IDLE: begin
                if (!i_ready && !d_ready && (i_req || d_req)) begin
                    grant = 1'b1;
                    if (misalign) begin
                        state_n = REJ;
                    end else if (sel_store) begin
`ifdef MEM_BUS_BYTE_LANE_EN
                        if (d_be == 4'h0) begin
                            state_n = REJ;
                        end else if (d_be != 4'hF) begin
                            state_n = RMW_RD;
                        end else begin
                            state_n = WR;
                        end
`else
                        state_n = WR;
`endif
                    end else begin
                        state_n = RD;
                    end
                end
            end
`ifdef MEM_BUS_BYTE_LANE_EN
            RMW_RD:  state_n = RMW_WR;
`endif
            default: state_n = IDLE;
        endcase
    end

`ifdef MEM_BUS_BYTE_LANE_EN
    // mem_wdata still holds the store data captured at grant; lanes not enabled keep old memory bytes.
    always_comb begin
        merged = mem_rdata;
        for (int unsigned b = 0; b < 4; b++) begin
            if (lat_be[b]) begin
                merged[8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            err        <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_instr    <= '0;
            d_rdata    <= '0;
            last_fetch <= 1'b1;
            cur_fetch  <= 1'b0;
`ifdef MEM_BUS_BYTE_LANE_EN
            lat_be     <= '0;
`endif
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            err     <= 1'b0;
            mem_we  <= 1'b0;
            if (grant) begin
                last_fetch <= sel_fetch;
                cur_fetch  <= sel_fetch;
                if (state_n != REJ) begin
                    mem_addr <= sel_addr[MEM_AW+1:2];
                end
                if (sel_store) begin
                    mem_wdata <= d_wdata;
                end
                mem_we <= (state_n == WR);
`ifdef MEM_BUS_BYTE_LANE_EN
                lat_be <= d_be;
`endif
            end
            case (state)
                RD: begin
                    if (cur_fetch) begin
                        i_instr <= mem_rdata;
                        i_ready <= 1'b1;
                    end else begin
                        d_rdata <= mem_rdata;
                        d_ready <= 1'b1;
                    end
                end
                WR: d_ready <= 1'b1;
                REJ: begin
                    err <= 1'b1;
                    if (cur_fetch) begin
                        i_ready <= 1'b1;
                    end else begin
                        d_ready <= 1'b1;
                    end
                end
`ifdef MEM_BUS_BYTE_LANE_EN
                RMW_RD: begin
                    mem_wdata <= merged;
                    mem_we    <= 1'b1;
                end
                RMW_WR: d_ready <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master with a word-array memory and a high-level access model.
// Exercises the byte-lane path as well when MEM_BUS_BYTE_LANE_EN is defined.
module tb_mem_bus_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_ready, d_req, d_we, d_ready, err, mem_we;
    logic [31:0] i_addr, i_instr, d_addr, d_wdata, d_rdata, mem_wdata, mem_rdata;
    logic [29:0] mem_addr;
`ifdef MEM_BUS_BYTE_LANE_EN
    logic [3:0]  d_be;
`endif

    always #5 clk = ~clk;

    mem_bus_master #(.MEM_AW(30), .ALIGN_CHK(1'b1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_instr(i_instr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
`ifdef MEM_BUS_BYTE_LANE_EN
        .d_be(d_be),
`endif
        .d_ready(d_ready), .d_rdata(d_rdata), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int unsigned i);
        return 32'(32'h2404_0000 + i * 3 + ((i ^ 2) << 20));
    endfunction

    // Memory: unwritten words read their initial pattern.
    logic [31:0] tbmem [64];
    bit          tb_written [64];
    int unsigned wr_count = 0;
    logic [29:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    assign mem_rdata = tb_written[mem_addr[5:0]] ? tbmem[mem_addr[5:0]] : init_word(32'(mem_addr[5:0]));

    always @(posedge clk) begin
        if (mem_we) begin
            tbmem[mem_addr[5:0]]      <= mem_wdata;
            tb_written[mem_addr[5:0]] <= 1'b1;
            wr_count                  <= wr_count + 1;
            last_wr_addr              <= mem_addr;
            last_wr_data              <= mem_wdata;
        end
    end

    // Reference model
    logic [31:0] ref_mem [64];
    logic [31:0] exp_instr, exp_drdata;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_instr  = '0;
        exp_drdata = '0;
    endtask

    task automatic do_access(input bit fetch, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, output int lat, output logic e,
                             output logic [31:0] rd, output int wrd);
        int unsigned w0;
        @(posedge clk); #1;
        w0 = wr_count;
        if (fetch) begin
            i_req = 1'b1; i_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end
        lat = -1; e = 1'b0; rd = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (fetch ? i_ready : d_ready) begin
                lat = c; e = err; rd = fetch ? i_instr : d_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        d_addr = $urandom; d_wdata = $urandom; i_addr = $urandom;
        wrd = int'(wr_count - w0);
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if ({i_ready, d_ready, err, mem_we} !== 4'b0) $display("FAIL reset_strobes: got %b expected 0000", {i_ready, d_ready, err, mem_we});
        else n_pass++;
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) $display("FAIL reset_mem: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
        else n_pass++;
        n_checks++;
        if (i_instr !== '0 || d_rdata !== '0) $display("FAIL reset_data: got instr %h rdata %h expected 0", i_instr, d_rdata);
        else n_pass++;
    endtask

    task automatic test_fetch();
        int lat, wrd; logic e; logic [31:0] rd;
        do_access(1'b1, 1'b0, 32'h8, '0, lat, e, rd, wrd);
        exp_instr = ref_mem[2];
        n_checks++;
        if (lat !== 2) $display("FAIL fetch_latency: got %0d expected 2", lat); else n_pass++;
        n_checks++;
        if (e !== 1'b0) $display("FAIL fetch_err: got %b expected 0", e); else n_pass++;
        n_checks++;
        if (rd !== 32'h2404_0006) $display("FAIL fetch_data: got %h expected 24040006", rd); else n_pass++;
    endtask

    task automatic test_store();
        int lat, wrd; logic e; logic [31:0] rd;
        do_access(1'b0, 1'b1, 32'h10, 32'h15, lat, e, rd, wrd);
        ref_mem[4] = 32'h15;
        n_checks++;
        if (lat !== 2) $display("FAIL store_latency: got %0d expected 2", lat); else n_pass++;
        n_checks++;
        if (wrd !== 1) $display("FAIL store_we_cycles: got %0d expected 1", wrd); else n_pass++;
        n_checks++;
        if (last_wr_addr !== 30'd4 || last_wr_data !== 32'h15) $display("FAIL store_bus: got addr %h data %h expected 4 / 15", last_wr_addr, last_wr_data);
        else n_pass++;
        n_checks++;
        if (e !== 1'b0 || rd !== exp_drdata) $display("FAIL store_resp: got err %b rdata %h expected 0 / %h", e, rd, exp_drdata);
        else n_pass++;
    endtask

    // Both held from reset: grants alternate data, fetch, ... every 3 cycles; ready 2 cycles after grant.
    task automatic test_both();
        logic exp_i, exp_d;
        apply_reset();
        @(posedge clk); #1;
        i_addr = 32'h40; d_addr = 32'h44; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_d = (c % 3 == 2) && ((c / 3) % 2 == 0);
            exp_i = (c % 3 == 2) && ((c / 3) % 2 == 1);
            n_checks++;
            if ({i_ready, d_ready} !== {exp_i, exp_d}) $display("FAIL both_ready_c%0d: got %b expected %b", c, {i_ready, d_ready}, {exp_i, exp_d});
            else n_pass++;
            if (exp_d) begin
                n_checks++;
                if (d_rdata !== ref_mem[17]) $display("FAIL both_drdata: got %h expected %h", d_rdata, ref_mem[17]); else n_pass++;
            end
            if (exp_i) begin
                n_checks++;
                if (i_instr !== ref_mem[16]) $display("FAIL both_instr: got %h expected %h", i_instr, ref_mem[16]); else n_pass++;
            end
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        exp_instr = ref_mem[16]; exp_drdata = ref_mem[17];
        repeat (3) @(posedge clk);
    endtask

    task automatic test_misaligned();
        int lat, wrd; logic e; logic [31:0] rd;
        do_access(1'b0, 1'b0, 32'h13, '0, lat, e, rd, wrd);
        n_checks++;
        if (lat !== 2 || e !== 1'b1) $display("FAIL misalign_resp: got lat %0d err %b expected 2 / 1", lat, e); else n_pass++;
        n_checks++;
        if (rd !== exp_drdata) $display("FAIL misalign_rdata: got %h expected %h", rd, exp_drdata); else n_pass++;
        n_checks++;
        if (wrd !== 0) $display("FAIL misalign_we: got %0d expected 0", wrd); else n_pass++;
    endtask

    task automatic test_random();
        int lat, wrd, exp_wrd; logic e, exp_e; logic [31:0] rd, addr, wdata, exp_rd;
        bit fetch, we; int unsigned word, off;
        for (int k = 0; k < 24; k++) begin
            fetch = ($urandom_range(0, 2) == 0);
            we    = !fetch && $urandom_range(0, 1) == 1;
            word  = $urandom_range(0, 63);
            off   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            addr  = 32'(word * 4 + off);
            wdata = $urandom;
            exp_e = (off != 0);
            exp_wrd = 0;
            if (!exp_e && we) begin
                ref_mem[word] = wdata; exp_wrd = 1;
            end else if (!exp_e && fetch) begin
                exp_instr = ref_mem[word];
            end else if (!exp_e) begin
                exp_drdata = ref_mem[word];
            end
            exp_rd = fetch ? exp_instr : exp_drdata;
            do_access(fetch, we, addr, wdata, lat, e, rd, wrd);
            n_checks++;
            if (lat !== 2) $display("FAIL rand%0d_latency: got %0d expected 2", k, lat); else n_pass++;
            n_checks++;
            if (e !== exp_e) $display("FAIL rand%0d_err: got %b expected %b", k, e, exp_e); else n_pass++;
            n_checks++;
            if (rd !== exp_rd) $display("FAIL rand%0d_data: got %h expected %h", k, rd, exp_rd); else n_pass++;
            n_checks++;
            if (wrd !== exp_wrd) $display("FAIL rand%0d_writes: got %0d expected %0d", k, wrd, exp_wrd); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int lat, wrd; logic e; logic [31:0] rd;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h20;
        @(posedge clk); #1;
        rst = 1'b1; i_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_instr = '0; exp_drdata = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (i_ready !== 1'b0 || mem_we !== 1'b0 || i_instr !== '0) $display("FAIL rstmid_c%0d: got ready %b we %b instr %h expected 0", c, i_ready, mem_we, i_instr);
            else n_pass++;
        end
        do_access(1'b1, 1'b0, 32'h24, '0, lat, e, rd, wrd);
        exp_instr = ref_mem[9];
        n_checks++;
        if (lat !== 2 || e !== 1'b0 || rd !== exp_instr) $display("FAIL rstmid_refetch: got lat %0d err %b data %h expected 2 / 0 / %h", lat, e, rd, exp_instr);
        else n_pass++;
    endtask

`ifdef MEM_BUS_BYTE_LANE_EN
    task automatic test_byte_lane();
        int lat, wrd; logic e; logic [31:0] rd;
        d_be = 4'hF;
        do_access(1'b0, 1'b1, 32'h28, 32'hAABBCCDD, lat, e, rd, wrd);
        d_be = 4'b0011;
        do_access(1'b0, 1'b1, 32'h28, 32'h11223344, lat, e, rd, wrd);
        n_checks++;
        if (lat !== 3 || e !== 1'b0 || wrd !== 1) $display("FAIL rmw_resp: got lat %0d err %b writes %0d expected 3 / 0 / 1", lat, e, wrd);
        else n_pass++;
        d_be = 4'h0;
        do_access(1'b0, 1'b1, 32'h28, 32'h0, lat, e, rd, wrd);
        n_checks++;
        if (lat !== 2 || e !== 1'b1 || wrd !== 0) $display("FAIL be0_reject: got lat %0d err %b writes %0d expected 2 / 1 / 0", lat, e, wrd);
        else n_pass++;
        d_be = 4'hF;
        ref_mem[10] = 32'hAABB3344;
        do_access(1'b0, 1'b0, 32'h28, '0, lat, e, rd, wrd);
        exp_drdata = ref_mem[10];
        n_checks++;
        if (rd !== 32'hAABB3344) $display("FAIL rmw_merge: got %h expected aabb3344", rd); else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
`ifdef MEM_BUS_BYTE_LANE_EN
        d_be = 4'hF;
`endif
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        exp_instr = '0; exp_drdata = '0;
        test_reset();
        test_fetch();
        test_store();
        test_both();
        test_misaligned();
        test_random();
        test_reset_mid();
`ifdef MEM_BUS_BYTE_LANE_EN
        test_byte_lane();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end
endmodule
